// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter.
// Holds default parameter values, the index-width helper and the
// encoding of the one-deep output stage.
package adder_share_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;

  // Smallest r with 2**r >= n (loop bounded so it elaborates as a constant).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_st_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per requester
//   last    - index granted most recently; search starts just above it
//   en      - when low, nothing is granted
//   gnt     - one-hot grant (all zero when nothing granted)
//   gnt_idx - binary index of the granted requester (0 when none)
//   gnt_any - high when some requester is granted
// The pointer register lives in the parent.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int N   = NREQ_DEF,
  parameter int IDW = clog2(NREQ_DEF)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  int idx_s;

  // Scan offsets 1..N above last (with wrap); the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_s   = 0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx_s = (int'(last) + k) % N;
        if (!gnt_any && req[idx_s]) begin
          gnt[idx_s] = 1'b1;
          gnt_idx    = IDW'(idx_s);
          gnt_any    = 1'b1;
        end else begin
          gnt_any = gnt_any;
        end
      end
    end else begin
      gnt_any = 1'b0;
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of a single WIDTH-bit adder among NREQ requesters.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready - result handshake to the single consumer
//   rsp_sum             - a+b with carry-out in the MSB
//   rsp_id              - index of the requester that produced rsp_sum
//   op_count            - results consumed, modulo 2**CNTW
//   busy                - result pending or any request present
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic [CNTW-1:0]       op_count,
  output logic                  busy
);

  out_st_e          state_q, state_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;

  logic             can_accept_s;
  logic             arb_en_s;
  logic [NREQ-1:0]  gnt_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic             gnt_any_s;
  logic             accept_s;
  logic             consume_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH:0]   adder_s;

  // rst_n gating keeps req_ready low while reset is held, so nothing can be
  // accepted on the edge where reset is released.
  assign can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
  assign arb_en_s     = can_accept_s && rst_n;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req     (req_valid),
    .last    (last_q),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  // Grants only go to valid requesters, so any grant is an accept.
  assign req_ready = gnt_s;
  assign accept_s  = gnt_any_s;
  assign consume_s = (state_q == ST_FULL) && rsp_ready;

  // Operand mux selected by the granted index feeding the single adder.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == IDW'(i)) begin
        a_sel_s = req_a[i*WIDTH +: WIDTH];
        b_sel_s = req_b[i*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  assign adder_s = {1'b0, a_sel_s} + {1'b0, b_sel_s};

  // Output stage next state, result load, priority pointer and counter.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rsp_ready && accept_s) begin
          state_d = ST_FULL;
        end else if (rsp_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (accept_s) begin
      sum_d  = adder_s;
      id_d   = gnt_idx_s;
      last_d = gnt_idx_s;
    end else begin
      sum_d  = sum_q;
    end
    if (consume_s) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q == ST_FULL) || (|req_valid);

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one WIDTH-bit adder among NREQ requesters using round-robin arbitration.
- Each requester offers an operand pair over a valid/ready handshake.
- Sums are registered with carry-out and tagged with the requester index.
- A one-deep output stage carries backpressure from a single consumer.
- Sits between requester blocks and the shared adder datapath, and is the only block that drives the adder.

Parameters:
- WIDTH, 8, operand width in bits.
- NREQ, 4, number of requesters; must be 2..16.
- IDW, 2, requester index width; must equal ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same packing as req_a.
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle when its valid is high.
- rsp_valid  out  1  result register holds a sum.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH+1  a+b with carry-out in the MSB.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- op_count  out  CNTW  number of results consumed; wraps modulo 2^CNTW.
- busy  out  1  high when rsp_valid is high or any req_valid bit is high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
  - Deassertion is handled as synchronous in effect: no accept in the same cycle that rst_n rises.
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational):
  - If can_accept, grant the first requester with req_valid set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready is one-hot for that requester; it is 0 if no requester is valid or can_accept=0.
  - req_ready never depends on req_a or req_b.
- Accept: occurs when req_valid[g] && req_ready[g]. On the next clk edge:
  - rsp_sum = zero-extended a + zero-extended b, WIDTH+1 bits, no truncation.
  - rsp_id = g.
  - rsp_valid = 1.
  - last_grant = g.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 op/cycle while rsp_ready stays high.
- Output FSM has two states:
  - EMPTY (rsp_valid=0):
    - accept -> FULL.
    - otherwise stay EMPTY.
  - FULL (rsp_valid=1):
    - rsp_ready && accept -> FULL; load the new result in the same edge (simultaneous drain and fill).
    - rsp_ready && !accept -> EMPTY.
    - !rsp_ready -> FULL; rsp_sum and rsp_id hold stable and req_ready=0.
- op_count increments by 1 on every cycle with rsp_valid && rsp_ready; it wraps from 2^CNTW-1 to 0.
- last_grant changes only on accept.
  - An idle cycle or a stalled cycle does not move priority.
  - A requester that drops valid before being granted loses nothing.
- Requesters must hold valid and operands stable until accepted. The block does not detect violations.
- Reset asserted mid-operation discards any pending result; no rsp_valid is produced for it.

Decomposition:
- Package adder_share_pkg holds:
  - Default constants WIDTH_DEF, NREQ_DEF.
  - Function clog2 for deriving IDW.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], last[IDW], en.
  - Outputs: gnt[N] one-hot, gnt_idx[IDW], gnt_any.
  - Purely combinational; pointer register stays in the top block.
- The adder itself is a plain assign in the top block: one instance, shared by mux on gnt_idx.

Test Plan:
- Reset then single request: req_valid=0001, a=8'h05, b=8'h03, rsp_ready=1 -> req_ready=0001 in cycle 0; next cycle rsp_valid=1, rsp_sum=9'h008, rsp_id=0; op_count=1 after it is consumed.
- Carry-out: a=8'hFF, b=8'h01 from requester 2 -> rsp_sum=9'h100, rsp_id=2.
- Round-robin fairness: req_valid=1111 held for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; one result per cycle; op_count=8.
- Backpressure: result held with rsp_ready=0 for 3 cycles while req_valid=0110 -> req_ready=0 and rsp_sum/rsp_id stable; when rsp_ready=1, drain and accept occur in the same cycle, no bubble; the next grant follows last_grant order.
- Counter wrap with CNTW=4: 17 consumed results -> op_count goes 15 -> 0 -> 1.
- Reset mid-op: assert rst_n=0 the cycle after an accept -> rsp_valid=0 immediately (asynchronous), op_count=0; after release with req_valid=1000, requester 3 is granted and the first-priority pointer starts at 0.
